// File: rtl/load_store_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_pkg
// Description : Shared definitions for the load/store unit: RV32 width codes,
//               FSM state encoding, memory word-index width and func3 helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_pkg;

  // RV32 load/store width codes carried on func3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Number of address bits forming the memory word index (ex_address[9:2])
  localparam int MEM_WORD_IDX = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } lsu_state_e;

  // Loads accept every width code, including the unsigned variants
  function automatic logic f3_load_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Stores have no unsigned variants: only SB, SH and SW exist
  function automatic logic f3_store_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_align.sv
`default_nettype none
// ============================================================================
// Module      : load_store_align
// Description : Combinational lane logic. Extracts and extends a byte/half/
//               word from a memory word for loads, and merges a sub-word
//               store operand into a previously read word.
// Ports       : func3_i      - width code
//               byte_off_i   - address bits [1:0]
//               load_word_i  - word to extract the load value from
//               base_word_i  - word captured by the read phase (merge base)
//               store_data_i - LSB-aligned store operand
//               load_value_o - extended load result
//               store_word_o - full word to write back
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_align
  import load_store_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] load_word_i,
  input  logic [31:0] base_word_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_value_o,
  output logic [31:0] store_word_o
);

  logic [4:0]  w_byte_sh;
  logic [4:0]  w_half_sh;
  logic [31:0] w_byte_lane;
  logic [31:0] w_half_lane;
  logic [31:0] w_byte_mask;
  logic [31:0] w_half_mask;

  // Halfword lane is chosen by addr[1] only; addr[0] is zero when aligned
  assign w_byte_sh   = {byte_off_i, 3'b000};
  assign w_half_sh   = {byte_off_i[1], 4'b0000};
  assign w_byte_lane = load_word_i >> w_byte_sh;
  assign w_half_lane = load_word_i >> w_half_sh;
  assign w_byte_mask = 32'h0000_00FF << w_byte_sh;
  assign w_half_mask = 32'h0000_FFFF << w_half_sh;

  always_comb begin
    load_value_o = load_word_i;
    case (func3_i)
      F3_B:    load_value_o = {{24{w_byte_lane[7]}}, w_byte_lane[7:0]};
      F3_BU:   load_value_o = {24'b0, w_byte_lane[7:0]};
      F3_H:    load_value_o = {{16{w_half_lane[15]}}, w_half_lane[15:0]};
      F3_HU:   load_value_o = {16'b0, w_half_lane[15:0]};
      default: load_value_o = load_word_i;
    endcase
  end

  always_comb begin
    store_word_o = store_data_i;
    case (func3_i)
      F3_B: store_word_o = (base_word_i & ~w_byte_mask) |
                           (({24'b0, store_data_i[7:0]} << w_byte_sh) & w_byte_mask);
      F3_H: store_word_o = (base_word_i & ~w_half_mask) |
                           (({16'b0, store_data_i[15:0]} << w_half_sh) & w_half_mask);
      default: store_word_o = store_data_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Pipeline-side load/store unit talking to a word-wide memory
//               with a busywait handshake. Sub-word stores are done as a
//               read-modify-write. Faulting requests and timed-out phases end
//               in DONE with a one-cycle access_fault pulse.
// Ports       : clk, reset (async, active-low)
//               ex_*        - pipeline request, held while stall=1
//               load_data   - extended load result (registered)
//               stall       - pipeline freeze
//               access_fault- one-cycle fault pulse (in DONE)
//               mem_*       - memory port; busywait low completes a phase
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import load_store_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MEM_WORDS      = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_func3,
  input  logic [31:0] ex_address,
  input  logic [31:0] ex_store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        access_fault,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_func3,
  input  logic [31:0] mem_rdata,
  input  logic        busywait
);

  localparam logic [7:0]  c_timeout    = 8'(TIMEOUT_CYCLES);
  localparam logic [31:0] c_addr_limit = 32'(4 * MEM_WORDS);

  lsu_state_e  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] load_data_q, load_data_d;
  logic        fault_q, fault_d;

  logic        w_req;
  logic        w_misaligned;
  logic        w_illegal;
  logic        w_bad_req;
  logic        w_timeout;
  logic [7:0]  w_wait_inc;
  logic [31:0] w_load_value;
  logic [31:0] w_store_word;

  assign w_req        = ex_mem_read | ex_mem_write;
  assign w_misaligned = (((ex_func3 == F3_H) || (ex_func3 == F3_HU)) && ex_address[0]) ||
                        ((ex_func3 == F3_W) && (ex_address[1:0] != 2'b00));
  assign w_illegal    = (ex_mem_read  && !f3_load_legal(ex_func3)) ||
                        (ex_mem_write && !f3_store_legal(ex_func3));
  assign w_bad_req    = (ex_mem_read && ex_mem_write) || w_illegal || w_misaligned ||
                        (ex_address >= c_addr_limit);

  // Timeout fires on the busy cycle that would take the count to the limit
  assign w_wait_inc   = wait_cnt_q + 8'd1;
  assign w_timeout    = busywait && (w_wait_inc == c_timeout);

  load_store_align u_align (
    .func3_i      (ex_func3),
    .byte_off_i   (ex_address[1:0]),
    .load_word_i  (mem_rdata),
    .base_word_i  (word_q),
    .store_data_i (ex_store_data),
    .load_value_o (w_load_value),
    .store_word_o (w_store_word)
  );

  // State register and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= 8'd0;
      word_q      <= 32'd0;
      load_data_q <= 32'd0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      word_q      <= word_d;
      load_data_q <= load_data_d;
      fault_q     <= fault_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    load_data_d = load_data_q;
    fault_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          if (w_bad_req) begin
            state_d = S_DONE;
            fault_d = 1'b1;
          end else if (ex_mem_write && (ex_func3 == F3_W)) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (!busywait) begin
          word_d = mem_rdata;
          if (ex_mem_write) begin
            state_d = S_WRITE;
          end else begin
            state_d     = S_DONE;
            load_data_d = w_load_value;
          end
        end else if (w_timeout) begin
          state_d = S_DONE;
          fault_d = 1'b1;
        end
      end
      S_WRITE: begin
        if (!busywait) begin
          state_d = S_DONE;
        end else if (w_timeout) begin
          state_d = S_DONE;
          fault_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Count restarts on every state change so each phase gets a fresh budget
    if (state_d != state_q) begin
      wait_cnt_d = 8'd0;
    end else if (busywait && ((state_q == S_READ) || (state_q == S_WRITE))) begin
      wait_cnt_d = w_wait_inc;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Outputs: strobes are decoded from the state so reset drops them at once
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = 32'd0;
    mem_wdata   = 32'd0;
    case (state_q)
      S_READ: begin
        mem_read    = 1'b1;
        mem_address = {{(32 - MEM_WORD_IDX){1'b0}}, ex_address[MEM_WORD_IDX+1:2]};
      end
      S_WRITE: begin
        mem_write   = 1'b1;
        mem_address = {{(32 - MEM_WORD_IDX){1'b0}}, ex_address[MEM_WORD_IDX+1:2]};
        mem_wdata   = w_store_word;
      end
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    endcase
  end

  assign stall        = w_req && (state_q != S_DONE);
  assign access_fault = fault_q;
  assign load_data    = load_data_q;
  assign mem_func3    = F3_W;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. A word memory with a
//               programmable busywait latency services the DUT; a per-access
//               reference model predicts strobes, write data, stall length,
//               fault and load results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
  import load_store_pkg::*;

  logic        clk;
  logic        reset;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_func3;
  logic [31:0] ex_address;
  logic [31:0] ex_store_data;
  logic [31:0] load_data;
  logic        stall;
  logic        access_fault;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_func3;
  logic [31:0] mem_rdata;
  logic        busywait;

  load_store_unit #(.TIMEOUT_CYCLES(255), .MEM_WORDS(256)) dut (
    .clk           (clk),
    .reset         (reset),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_func3      (ex_func3),
    .ex_address    (ex_address),
    .ex_store_data (ex_store_data),
    .load_data     (load_data),
    .stall         (stall),
    .access_fault  (access_fault),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_wdata     (mem_wdata),
    .mem_func3     (mem_func3),
    .mem_rdata     (mem_rdata),
    .busywait      (busywait)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory environment ----------------
  logic [31:0] mem [256];
  int          cur_lat   = 1;
  bit          cur_force = 1'b0;
  int          phase_cnt = 0;
  logic        s_rd, s_wr, s_bw;
  logic [7:0]  s_idx;
  logic [31:0] s_wd;

  always @(posedge clk) begin
    s_rd  = mem_read;
    s_wr  = mem_write;
    s_bw  = busywait;
    s_idx = mem_address[7:0];
    s_wd  = mem_wdata;
    if (s_wr && !s_bw) mem[s_idx] = s_wd;
    if ((s_rd || s_wr) && s_bw) phase_cnt++;
    else phase_cnt = 0;
    #1;
    busywait  = (mem_read || mem_write) && (cur_force || (phase_cnt < cur_lat));
    mem_rdata = mem[mem_address[7:0]];
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b [4];
    logic [15:0] h;
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    h = {b[{off[1], 1'b1}], b[{off[1], 1'b0}]};
    case (f3)
      3'b000:  return {{24{b[off][7]}}, b[off]};
      3'b100:  return {24'h0, b[off]};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_merge(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w, input logic [31:0] sd);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    case (f3)
      3'b000: b[off] = sd[7:0];
      3'b001: begin
        b[{off[1], 1'b0}] = sd[7:0];
        b[{off[1], 1'b1}] = sd[15:8];
      end
      default: return sd;
    endcase
    return {b[3], b[2], b[1], b[0]};
  endfunction

  bit          chk_on        = 1'b0;
  bit          txn_active    = 1'b0;
  bit          exp_has_read  = 1'b0;
  bit          exp_has_write = 1'b0;
  bit          exp_fault     = 1'b0;
  logic [7:0]  exp_idx       = 8'h0;
  logic [31:0] exp_wdata     = 32'h0;
  logic [31:0] exp_ld_done   = 32'h0;
  logic [31:0] model_ld      = 32'h0;
  int          last_stall    = 0;
  logic        last_fault    = 1'b0;

  // Per-cycle compare against the model
  always @(negedge clk) begin
    #2;
    if (chk_on) begin
      chk("mem_func3", {29'b0, mem_func3}, 32'h2);
      chk("strobe_exclusive", {31'b0, mem_read & mem_write}, 32'h0);
      if (mem_read)  chk("read_allowed", {31'b0, txn_active & exp_has_read}, 32'h1);
      if (mem_write) begin
        chk("write_allowed", {31'b0, txn_active & exp_has_write}, 32'h1);
        chk("mem_wdata", mem_wdata, exp_wdata);
      end
      if (mem_read || mem_write) chk("mem_address", mem_address, {24'h0, exp_idx});
      if (txn_active && !stall) begin
        chk("done_load_data", load_data, exp_ld_done);
        chk("done_fault", {31'b0, access_fault}, {31'b0, exp_fault});
      end else begin
        chk("load_data_hold", load_data, model_ld);
        chk("fault_quiet", {31'b0, access_fault}, 32'h0);
      end
    end
  end

  // One access; entered and left at a negedge
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input int lat, input bit force_busy);
    bit          fault_req, timeout, done;
    int          nph, exp_stall, n;
    logic [31:0] old, exp_after;
    fault_req = (rd && wr) || (rd && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) ||
                (wr && !(f3 inside {3'b000, 3'b001, 3'b010})) ||
                ((f3 == 3'b001 || f3 == 3'b101) && addr[0]) ||
                (f3 == 3'b010 && addr[1:0] != 2'b00) || (addr >= 32'd1024);
    timeout   = !fault_req && force_busy;
    exp_idx   = addr[9:2];
    old       = mem[exp_idx];
    nph       = fault_req ? 0 : (rd ? 1 : (f3 == 3'b010 ? 1 : 2));
    exp_stall = fault_req ? 1 : (timeout ? 256 : 1 + nph * (lat + 1));
    exp_has_read  = !fault_req && (rd || f3 != 3'b010);
    exp_has_write = !fault_req && wr;
    exp_wdata     = wr ? ref_merge(f3, addr[1:0], old, sd) : 32'h0;
    exp_fault     = fault_req || timeout;
    exp_ld_done   = (rd && !exp_fault) ? ref_load(f3, addr[1:0], old) : model_ld;
    exp_after     = (exp_has_write && !timeout) ? exp_wdata : old;
    cur_lat       = lat;
    cur_force     = force_busy;
    txn_active    = 1'b1;
    ex_mem_read   = rd;
    ex_mem_write  = wr;
    ex_func3      = f3;
    ex_address    = addr;
    ex_store_data = sd;
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 600; c++) begin
      #1;
      if (stall) n++;
      else begin
        done = 1'b1;
        last_fault = access_fault;
        break;
      end
      @(negedge clk);
    end
    if (!done) begin
      errors++;
      $display("FAIL stall_bound actual=%0d expected=%0d", n, exp_stall);
    end
    last_stall = n;
    chk("stall_cycles", 32'(n), 32'(exp_stall));
    @(negedge clk);
    model_ld     = exp_ld_done;
    txn_active   = 1'b0;
    cur_force    = 1'b0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    chk("mem_after", mem[exp_idx], exp_after);
  endtask

  logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [2:0] st_f3 [3] = '{3'b000, 3'b001, 3'b010};
  logic [2:0] bad_f3[3] = '{3'b011, 3'b110, 3'b111};

  initial begin
    logic [31:0] a, old9;
    logic [2:0]  f;
    int          kind;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    busywait      = 1'b0;
    mem_rdata     = 32'h0;
    reset         = 1'b0;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
    ex_func3      = 3'b010;
    ex_address    = 32'h0000_03FC;
    ex_store_data = 32'hDEAD_BEEF;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'h0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'h0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_fault", {31'b0, access_fault}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk_on = 1'b1;

    // Signed / unsigned byte loads
    mem[5] = 32'h8000_7F80;
    run_txn(1'b1, 1'b0, 3'b000, 32'h14, 32'h0, 1, 1'b0);
    chk("lb_0x14", load_data, 32'hFFFF_FF80);
    chk("lb_stall", 32'(last_stall), 32'd3);
    run_txn(1'b1, 1'b0, 3'b100, 32'h15, 32'h0, 1, 1'b0);
    chk("lbu_0x15", load_data, 32'h0000_007F);

    // Read-modify-write byte store
    mem[5] = 32'h1122_3344;
    run_txn(1'b0, 1'b1, 3'b000, 32'h16, 32'h0000_00AB, 1, 1'b0);
    chk("sb_word5", mem[5], 32'h11AB_3344);
    chk("sb_stall", 32'(last_stall), 32'd5);

    // Misaligned word load
    run_txn(1'b1, 1'b0, 3'b010, 32'h13, 32'h0, 1, 1'b0);
    chk("lw_mis_fault", {31'b0, last_fault}, 32'h1);
    chk("lw_mis_stall", 32'(last_stall), 32'd1);
    chk("lw_mis_ld_hold", load_data, 32'h0000_007F);

    // Store word with memory stuck busy
    mem[8] = 32'hCAFE_F00D;
    run_txn(1'b0, 1'b1, 3'b010, 32'h20, 32'h1234_5678, 1, 1'b1);
    chk("sw_to_fault", {31'b0, last_fault}, 32'h1);
    chk("sw_to_stall", 32'(last_stall), 32'd256);
    chk("sw_to_nowrite", mem[8], 32'hCAFE_F00D);
    chk("sw_to_idle", 32'(dut.state_q), 32'(S_IDLE));

    // Read and write requested together
    run_txn(1'b1, 1'b1, 3'b010, 32'h20, 32'h0, 1, 1'b0);
    chk("rw_fault", {31'b0, last_fault}, 32'h1);
    chk("rw_stall", 32'(last_stall), 32'd1);

    // Reset during the write phase of a halfword store
    chk_on        = 1'b0;
    old9          = mem[9];
    cur_lat       = 3;
    ex_func3      = 3'b001;
    ex_address    = 32'h24;
    ex_store_data = 32'h0000_BEEF;
    ex_mem_write  = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_write) break;
    end
    chk("rst_mid_in_write", {31'b0, mem_write}, 32'h1);
    reset = 1'b0;
    #1;
    chk("rst_mid_rd", {31'b0, mem_read}, 32'h0);
    chk("rst_mid_wr", {31'b0, mem_write}, 32'h0);
    chk("rst_mid_state", 32'(dut.state_q), 32'(S_IDLE));
    ex_mem_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b1;
    model_ld = 32'h0;
    @(negedge clk);
    chk("rst_mid_word9", mem[9], old9);
    chk_on = 1'b1;

    // Randomized traffic
    for (int t = 0; t < 120; t++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 3 || kind == 9) f = (kind == 9) ? bad_f3[$urandom_range(0, 2)]
                                                   : ld_f3[$urandom_range(0, 4)];
      else f = st_f3[$urandom_range(0, 2)];
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else begin
        a = 32'($urandom_range(0, 1023));
        if ($urandom_range(0, 3) != 0) begin
          if (f == 3'b010) a = a & ~32'h3;
          else if (f == 3'b001 || f == 3'b101) a = a & ~32'h1;
        end
      end
      run_txn((kind <= 3 || kind >= 8) ? 1'b1 : 1'b0,
              (kind >= 4 && kind <= 8) ? 1'b1 : 1'b0,
              f, a, $urandom, $urandom_range(0, 3), 1'b0);
    end

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
